seg7_pattern_encoder: RTL and testbench
=======================================

// Module: seg7_pattern_encoder
// PURPOSE
//   Receiving end of the 7-segment display interface. Samples an 8-bit segment bus and
//   recovers the 3-bit code (0-7) that produced it. A pattern is accepted only after it
//   has been stable for a configurable time. The code is delivered on a valid/ready
//   handshake, and unknown patterns are flagged. Sits between a segment bus capture
//   point and downstream control logic.
// PARAMETERS
//   STABLE_CYCLES  4  consecutive cycles a synced pattern must hold before qualifying (>=1)
//   SYNC_STAGES    2  flip-flop depth of the input synchroniser (>=2)
// PORTS
//   clk            in   1  single clock, rising edge
//   reset_n        in   1  asynchronous, active-low reset
//   seg_in         in   8  segment bus, active-low; [7]=dp, [6:0]=g..a; asynchronous to clk
//   out_code       out  3  recovered code; valid while out_valid=1
//   out_valid      out  1  code available
//   out_ready      in   1  consumer accepts; transfer when out_valid & out_ready
//   err_pulse      out  1  1-cycle pulse: a qualified pattern is not in the table
//   overrun_pulse  out  1  1-cycle pulse: a pattern qualified while a code was pending
// BEHAVIOUR
//   Reset (async assert, sync release): sync regs=8'hFF, out_code=0, out_valid=0,
//     err_pulse=0, overrun_pulse=0, stability counter=0, FSM=S_HOLD with last=8'hFF.
//   Table, active-low with dp off: 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8.
//   Stability: counter clears when synced pattern != previous synced pattern.
//     Otherwise it increments, saturating. The pattern qualifies in the cycle its
//     STABLE_CYCLES-th consecutive held cycle completes.
//   Latency: seg_in change -> out_valid high after SYNC_STAGES+STABLE_CYCLES+1 edges
//     (7 at defaults).
//   FSM S_HOLD: wait for a qualified pattern != last.
//     Blank 8'hFF -> last updated, no output.
//     Table hit -> out_code latched, out_valid=1, last updated, go to S_EMIT.
//     Miss -> err_pulse, last updated, stay in S_HOLD.
//   FSM S_EMIT: out_valid and out_code held stable until out_ready.
//     On transfer -> out_valid=0, last = current synced pattern, go to S_HOLD.
//     Qualification of a different pattern while in S_EMIT -> overrun_pulse; that
//       pattern is discarded.
//     Transfer and overrun in the same cycle -> both occur; the pattern is discarded.
//   A repeated pattern equal to last never re-emits. A new emission requires a change.
//   Glitches shorter than STABLE_CYCLES are never reported.
//   reset_n low mid-count or mid-handshake: all state returns to reset values immediately.
// CONFIGURATION
//   SEG7_DP_CHECK_EN defined: lit dp (seg_in[7]=0) makes any pattern a miss (err_pulse).
//   SEG7_DP_CHECK_EN undefined: seg_in[7] is ignored; matching uses [6:0] only.
//   Blank detection follows the same rule in both cases.
// STRUCTURE
//   Package seg7_pkg holds:
//     - SEG_BLANK (8'hFF)
//     - SEG_TABLE[0:7] constants
//     - seg_t typedef (logic [7:0])
//     - state enum {S_HOLD, S_EMIT}
//   Sub-module seg7_stability_filter contains the synchroniser, the counter and the
//     qualify strobe with the qualified pattern. The top contains the table lookup
//     and the FSM.
// TESTING
//   1. Reset, seg_in=FF for 20 cycles -> out_valid, err_pulse and overrun_pulse stay 0.
//   2. seg_in=A4, out_ready=1 -> out_valid=1 for 1 cycle, 7 edges after change,
//      out_code=2.
//   3. seg_in=99 for 3 cycles, then B0 held -> single emission with code 3;
//      code 4 never seen.
//   4. seg_in=AA held -> exactly one err_pulse; no out_valid.
//   5. out_ready=0, seg_in=92 then F8 held -> code 5 held and one overrun_pulse.
//      Raise out_ready -> one transfer; code 7 is not emitted.
//   6. reset_n low during counting for A4 -> outputs 0 asynchronously.
//      After release with seg_in=A4 held -> code 2 emitted 7 edges after release.
//   Per macro, seg_in=40 -> err_pulse with SEG7_DP_CHECK_EN; out_code=0 without it.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment pattern encoder: segment encodings and FSM states.
// Pure declarations (no latency, no flow control).
package seg7_pkg;

    typedef logic [7:0] seg_t;

    localparam seg_t SEG_BLANK = 8'hFF;

    // Active-low segment encodings for codes 0..7, decimal point off.
    localparam seg_t SEG_TABLE [0:7] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8
    };

    typedef enum logic {
        S_HOLD = 1'b0,
        S_EMIT = 1'b1
    } state_e;

endpackage

// File: rtl/seg7_pattern_encoder_if.sv
// Segment bus input plus the recovered-code valid/ready channel and its status pulses.
// Wiring only (no latency); the consumer pushes back through out_ready.
interface seg7_pattern_encoder_if;

    logic [7:0] seg_in;
    logic [2:0] out_code;
    logic       out_valid;
    logic       out_ready;
    logic       err_pulse;
    logic       overrun_pulse;

    modport master (
        input  seg_in,
        input  out_ready,
        output out_code,
        output out_valid,
        output err_pulse,
        output overrun_pulse
    );

    modport slave (
        output seg_in,
        output out_ready,
        input  out_code,
        input  out_valid,
        input  err_pulse,
        input  overrun_pulse
    );

endinterface

// File: rtl/seg7_stability_filter.sv
// Synchronises the segment bus and strobes qual_o when a pattern has held for STABLE_CYCLES.
// Latency: SYNC_STAGES+STABLE_CYCLES edges to the strobe; free-running, no backpressure.
module seg7_stability_filter
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  seg_t seg_i,
    output seg_t synced_o,
    output logic qual_o
);

    localparam int              CW       = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_MAX  = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0]   QUAL_AT  = CW'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0][7:0] sync_q;
    seg_t                        prev_q;
    logic [CW-1:0]               cnt_q;
    logic [CW-1:0]               cnt_d;
    logic                        held;

    assign synced_o = sync_q[SYNC_STAGES-1];
    assign held     = (synced_o == prev_q);

    always_comb begin
        cnt_d = cnt_q;
        if (!held) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Saturation keeps the strobe to a single cycle per stable run.
    assign qual_o = held && (cnt_q == QUAL_AT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '1;
            prev_q <= SEG_BLANK;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], seg_i};
            prev_q <= synced_o;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/seg7_pattern_encoder.sv
// Recovers a 3-bit code from a stable 7-segment pattern and offers it on valid/ready; SEG7_DP_CHECK_EN rejects lit dp.
// Latency: SYNC_STAGES+STABLE_CYCLES+1 edges; holds the code until out_ready, newer patterns are dropped as overruns.
module seg7_pattern_encoder
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    seg7_pattern_encoder_if.master enc_if
);

    seg_t       synced;
    logic       qual;
    logic       is_new;
    logic       hit;
    logic [2:0] hit_code;

    state_e     state_q, state_d;
    logic [2:0] code_q, code_d;
    logic       valid_q, valid_d;
    seg_t       last_q, last_d;
    logic       err_q, err_d;
    logic       ovr_q, ovr_d;

    seg7_stability_filter #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .SYNC_STAGES   (SYNC_STAGES)
    ) u_filter (
        .clk      (clk),
        .reset_n  (reset_n),
        .seg_i    (enc_if.seg_in),
        .synced_o (synced),
        .qual_o   (qual)
    );

    always_comb begin
        hit      = 1'b0;
        hit_code = '0;
        for (int i = 0; i < 8; i++) begin
`ifdef SEG7_DP_CHECK_EN
            if (synced == SEG_TABLE[i]) begin
`else
            if (synced[6:0] == SEG_TABLE[i][6:0]) begin
`endif
                hit      = 1'b1;
                hit_code = 3'(i);
            end
        end
    end

    assign is_new = qual && (synced != last_q);

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        valid_d = valid_q;
        last_d  = last_q;
        err_d   = 1'b0;
        ovr_d   = 1'b0;
        case (state_q)
            S_HOLD: begin
                if (is_new) begin
                    last_d = synced;
                    if (synced != SEG_BLANK) begin
                        if (hit) begin
                            code_d  = hit_code;
                            valid_d = 1'b1;
                            state_d = S_EMIT;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                ovr_d = is_new;
                // Re-arming on the live pattern stops it re-emitting after the transfer.
                if (enc_if.out_ready) begin
                    valid_d = 1'b0;
                    last_d  = synced;
                    state_d = S_HOLD;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_HOLD;
            code_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= SEG_BLANK;
            err_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            err_q   <= err_d;
            ovr_q   <= ovr_d;
        end
    end

    assign enc_if.out_code      = code_q;
    assign enc_if.out_valid     = valid_q;
    assign enc_if.err_pulse     = err_q;
    assign enc_if.overrun_pulse = ovr_q;

endmodule

// File: tb/tb_seg7_pattern_encoder.sv
// Directed and random stimulus for seg7_pattern_encoder, checked every cycle against a
// run-length reference model plus explicit latency/count expectations.
module tb_seg7_pattern_encoder;

    localparam int STABLE = 4;
    localparam int SYNC   = 2;
    localparam logic [7:0] REF_TBL [8] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8
    };

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    seg7_pattern_encoder_if enc_if ();

    seg7_pattern_encoder #(
        .STABLE_CYCLES (STABLE),
        .SYNC_STAGES   (SYNC)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .enc_if  (enc_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [7:0] m_hist [$];
    logic [7:0] m_synced;
    int         m_run;
    bit         m_qual;
    bit         m_pend;
    logic [2:0] m_code;
    logic [7:0] m_last;
    bit         m_err;
    bit         m_ovr;

    int n_valid, n_err, n_ovr, n_xfer;
    bit saw4, saw7;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_lookup(input logic [7:0] p, output logic [2:0] c);
        c = '0;
        for (int i = 0; i < 8; i++) begin
`ifdef SEG7_DP_CHECK_EN
            if (p == REF_TBL[i]) begin
`else
            if ((p | 8'h80) == REF_TBL[i]) begin
`endif
                c = 3'(i);
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_hist.delete();
        for (int i = 0; i < SYNC; i++) m_hist.push_back(8'hFF);
        m_synced = 8'hFF;
        m_run    = 2;
        m_qual   = (m_run == STABLE + 1);
        m_pend   = 1'b0;
        m_code   = '0;
        m_last   = 8'hFF;
        m_err    = 1'b0;
        m_ovr    = 1'b0;
    endtask

    // One clock edge: decide outputs from last cycle's qualification, then advance the synchroniser view.
    task automatic model_step(input logic [7:0] seg_e, input bit rdy_e);
        logic [2:0] c;
        logic [7:0] nxt;
        m_err = 1'b0;
        m_ovr = 1'b0;
        if (!m_pend) begin
            if (m_qual && m_synced != m_last) begin
                m_last = m_synced;
                if (m_synced != 8'hFF) begin
                    if (m_lookup(m_synced, c)) begin
                        m_code = c;
                        m_pend = 1'b1;
                    end else begin
                        m_err = 1'b1;
                    end
                end
            end
        end else begin
            if (m_qual && m_synced != m_last) m_ovr = 1'b1;
            if (rdy_e) begin
                m_pend = 1'b0;
                m_last = m_synced;
            end
        end
        m_hist.push_front(seg_e);
        void'(m_hist.pop_back());
        nxt = m_hist[SYNC-1];
        if (nxt == m_synced) begin
            if (m_run < 1000) m_run++;
        end else begin
            m_run = 1;
        end
        m_synced = nxt;
        m_qual   = (m_run == STABLE + 1);
    endtask

    task automatic tick();
        logic [7:0] seg_e;
        bit rdy_e;
        bit pre_x;
        seg_e = enc_if.seg_in;
        rdy_e = enc_if.out_ready;
        pre_x = enc_if.out_valid && enc_if.out_ready;
        @(posedge clk);
        #1;
        if (!reset_n) model_reset();
        else model_step(seg_e, rdy_e);
        if (pre_x) n_xfer++;
        if (enc_if.out_valid) begin
            n_valid++;
            if (enc_if.out_code == 3'd4) saw4 = 1'b1;
            if (enc_if.out_code == 3'd7) saw7 = 1'b1;
        end
        if (enc_if.err_pulse) n_err++;
        if (enc_if.overrun_pulse) n_ovr++;
        check("valid", 8'(enc_if.out_valid), 8'(m_pend));
        if (m_pend) check("code", 8'(enc_if.out_code), 8'(m_code));
        check("err_pulse", 8'(enc_if.err_pulse), 8'(m_err));
        check("overrun_pulse", 8'(enc_if.overrun_pulse), 8'(m_ovr));
    endtask

    task automatic clear_stats();
        n_valid = 0; n_err = 0; n_ovr = 0; n_xfer = 0;
        saw4 = 1'b0; saw7 = 1'b0;
    endtask

    task automatic hold(input logic [7:0] pat, input int n);
        enc_if.seg_in = pat;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic edges_to_valid(output int n);
        n = 0;
        while (!enc_if.out_valid && n < 30) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        logic [7:0] pat;
        int r;

        enc_if.seg_in    = 8'hFF;
        enc_if.out_ready = 1'b0;
        model_reset();
        clear_stats();
        #12;
        check("rst_valid", 8'(enc_if.out_valid), 8'd0);
        check("rst_code", 8'(enc_if.out_code), 8'd0);
        check("rst_err", 8'(enc_if.err_pulse), 8'd0);
        check("rst_ovr", 8'(enc_if.overrun_pulse), 8'd0);
        reset_n = 1'b1;

        // Blank bus after reset produces nothing.
        hold(8'hFF, 20);
        check("blank_valid_cnt", 8'(n_valid), 8'd0);
        check("blank_err_cnt", 8'(n_err), 8'd0);
        check("blank_ovr_cnt", 8'(n_ovr), 8'd0);

        // Code 2, latency 7 edges, single-cycle valid with ready high.
        enc_if.out_ready = 1'b1;
        enc_if.seg_in    = 8'hA4;
        edges_to_valid(n);
        check("lat_a4", 8'(n), 8'd7);
        check("code_a4", 8'(enc_if.out_code), 8'd2);
        tick();
        check("a4_one_cycle", 8'(enc_if.out_valid), 8'd0);

        // Short 99 glitch then B0: only code 3.
        clear_stats();
        hold(8'h99, 3);
        hold(8'hB0, 15);
        check("b0_emit_cnt", 8'(n_valid), 8'd1);
        check("glitch_code4", 8'(saw4), 8'd0);

        // Unknown pattern: one err pulse, no emission.
        clear_stats();
        hold(8'hAA, 15);
        check("aa_err_cnt", 8'(n_err), 8'd1);
        check("aa_valid_cnt", 8'(n_valid), 8'd0);

        // Held code 5 with an overrun from F8; F8 never emitted.
        enc_if.out_ready = 1'b0;
        hold(8'h92, 12);
        clear_stats();
        hold(8'hF8, 12);
        check("hold_valid", 8'(enc_if.out_valid), 8'd1);
        check("hold_code5", 8'(enc_if.out_code), 8'd5);
        check("ovr_cnt", 8'(n_ovr), 8'd1);
        enc_if.out_ready = 1'b1;
        clear_stats();
        hold(8'hF8, 12);
        check("xfer_cnt", 8'(n_xfer), 8'd1);
        check("f8_never", 8'(saw7), 8'd0);

        // Reset mid-count: immediate clear, then clean restart.
        hold(8'hA4, 3);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_valid", 8'(enc_if.out_valid), 8'd0);
        check("arst_code", 8'(enc_if.out_code), 8'd0);
        check("arst_err", 8'(enc_if.err_pulse), 8'd0);
        check("arst_ovr", 8'(enc_if.overrun_pulse), 8'd0);
        model_reset();
        tick();
        tick();
        reset_n = 1'b1;
        edges_to_valid(n);
        check("lat_after_rst", 8'(n), 8'd7);
        check("code_after_rst", 8'(enc_if.out_code), 8'd2);

        // Lit decimal point.
        hold(8'hFF, 12);
        clear_stats();
        hold(8'h40, 12);
`ifdef SEG7_DP_CHECK_EN
        check("dp_err_cnt", 8'(n_err), 8'd1);
        check("dp_valid_cnt", 8'(n_valid), 8'd0);
`else
        check("dp_valid_cnt", 8'(n_valid), 8'd1);
        check("dp_err_cnt", 8'(n_err), 8'd0);
`endif

        // Random patterns, hold times and ready.
        for (int s = 0; s < 150; s++) begin
            r = int'($urandom_range(0, 9));
            if (r < 8) pat = REF_TBL[r];
            else if (r == 8) pat = 8'hFF;
            else pat = 8'($urandom);
            enc_if.seg_in = pat;
            n = int'($urandom_range(1, 8));
            for (int k = 0; k < n; k++) begin
                enc_if.out_ready = 1'($urandom_range(0, 1));
                tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
